multicycle_controller: RTL and testbench

- Control unit for the multicycle RISC-V core.
- Sits directly upstream of the datapath and drives every datapath enable and mux select, cycle by cycle.
- Consumes the opcode and funct fields from the datapath's instruction register, plus the ALU zero flag.
- Contains the main-decoder FSM, the ALU decoder and the immediate-source decoder. Supports lw, sw, R-type, I-type ALU, beq and jal.

---
 rtl/multicycle_controller.sv | 186 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - control unit (main FSM, ALU decoder, immediate decoder) for the multicycle RISC-V core
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset (forces FETCH)
//   op, funct3, funct7b5  instruction fields from the instruction register
//   zero                  ALU zero flag, only honoured in BEQ
//   PCWrite               PC enable: PCUpdate | (Branch & zero)
//   AdrSrc, MemWrite      memory address select and data memory write enable
//   IRWrite               instruction register / OldPC enable
//   ResultSrc             00 ALUOut, 01 Data, 10 ALUResult
//   ALUSrcA, ALUSrcB      ALU operand selects
//   ImmSrc                extend unit select (I/S/B/J)
//   ALUControl            ALU operation
//   RegWrite              register file write enable
//   state                 current FSM state (debug)
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               zero,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ImmSrc,
  output logic [2:0]         ALUControl,
  output logic               RegWrite,
  output logic [STATE_W-1:0] state
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [STATE_W-1:0] {
    FETCH    = STATE_W'(0),
    DECODE   = STATE_W'(1),
    MEMADR   = STATE_W'(2),
    MEMREAD  = STATE_W'(3),
    MEMWB    = STATE_W'(4),
    MEMWRITE = STATE_W'(5),
    EXECUTER = STATE_W'(6),
    ALUWB    = STATE_W'(7),
    EXECUTEI = STATE_W'(8),
    JAL      = STATE_W'(9),
    BEQ      = STATE_W'(10)
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic       pcupdate;
  logic       branch;
  logic [1:0] aluop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = FETCH;
    pcupdate  = 1'b0;
    branch    = 1'b0;
    aluop     = 2'b00;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    RegWrite  = 1'b0;
    case (state_q)
      FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pcupdate  = 1'b1;
        state_d   = DECODE;
      end
      DECODE: begin
        // ALU precomputes OldPC + imm so BEQ/JAL find the target in ALUOut
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:          state_d = EXECUTER;
          OP_ITYPE:          state_d = EXECUTEI;
          OP_BEQ:            state_d = BEQ;
          OP_JAL:            state_d = JAL;
          default:           state_d = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        state_d   = FETCH;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        state_d  = FETCH;
      end
      EXECUTER: begin
        ALUSrcA = 2'b10;
        aluop   = 2'b10;
        state_d = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        aluop   = 2'b10;
        state_d = ALUWB;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        state_d  = FETCH;
      end
      BEQ: begin
        ALUSrcA = 2'b10;
        aluop   = 2'b01;
        branch  = 1'b1;
        state_d = FETCH;
      end
      JAL: begin
        // PC <= target held in ALUOut; ALU forms OldPC + 4 for the link write
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pcupdate = 1'b1;
        state_d  = ALUWB;
      end
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    case (op)
      OP_STORE: ImmSrc = 2'b01;
      OP_BEQ:   ImmSrc = 2'b10;
      OP_JAL:   ImmSrc = 2'b11;
      default:  ImmSrc = 2'b00;
    endcase
  end

  always_comb begin
    case (aluop)
      2'b01:   ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          // funct7b5 selects sub only for R-type; addi immediates may set bit 30
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  assign PCWrite = pcupdate | (branch & zero);
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller
module tb_multicycle_controller;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3;
  localparam logic [3:0] S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECUTER = 4'd6, S_ALUWB = 4'd7;
  localparam logic [3:0] S_EXECUTEI = 4'd8, S_JAL = 4'd9, S_BEQ = 4'd10;

  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;
  logic [19:0] sb[$];

  multicycle_controller #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .RegWrite(RegWrite), .state(state)
  );

  always #5 clk = ~clk;

  // Vector layout: state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, RegWrite
  function automatic logic [19:0] expv(input logic [3:0] st, input logic [6:0] o,
                                       input logic [2:0] f3, input logic f7, input logic z);
    logic pcw, adr, mw, irw, rw;
    logic [1:0] rs, sa, sbb, imm;
    logic [2:0] ac, rdec;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; rs = 0; sa = 0; sbb = 0; ac = 0;
    case (o)
      OP_SW:   imm = 2'b01;
      OP_BEQ:  imm = 2'b10;
      OP_JAL:  imm = 2'b11;
      default: imm = 2'b00;
    endcase
    case (f3)
      3'b000:  rdec = (o[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  rdec = 3'b101;
      3'b110:  rdec = 3'b011;
      3'b111:  rdec = 3'b010;
      default: rdec = 3'b000;
    endcase
    case (st)
      S_FETCH:    begin irw = 1; sbb = 2; rs = 2; pcw = 1; end
      S_DECODE:   begin sa = 1; sbb = 1; end
      S_MEMADR:   begin sa = 2; sbb = 1; end
      S_MEMREAD:  begin adr = 1; end
      S_MEMWB:    begin rs = 1; rw = 1; end
      S_MEMWRITE: begin adr = 1; mw = 1; end
      S_EXECUTER: begin sa = 2; ac = rdec; end
      S_EXECUTEI: begin sa = 2; sbb = 1; ac = rdec; end
      S_ALUWB:    begin rw = 1; end
      S_BEQ:      begin sa = 2; ac = 3'b001; pcw = z; end
      S_JAL:      begin sa = 1; sbb = 2; pcw = 1; end
      default:    ;
    endcase
    return {st, pcw, adr, mw, irw, rs, sa, sbb, imm, ac, rw};
  endfunction

  function automatic int exp_cpi(input logic [6:0] o);
    case (o)
      OP_LW:                     return 5;
      OP_SW, OP_R, OP_I, OP_JAL: return 4;
      OP_BEQ:                    return 3;
      default:                   return 2;
    endcase
  endfunction

  // Scoreboard consumer: one expected vector per cycle, compared mid-cycle
  always @(negedge clk) begin
    logic [19:0] act, e;
    act = {state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, RegWrite};
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL outputs t=%0t actual=%05h expected=%05h", $time, act, e);
      end
    end
    checks++;
    if ((MemWrite === 1'b1) && (RegWrite === 1'b1 || IRWrite === 1'b1)) begin
      errors++;
      $display("FAIL write_exclusive t=%0t MemWrite=%b RegWrite=%b IRWrite=%b expected no overlap",
               $time, MemWrite, RegWrite, IRWrite);
    end
  end

  // Entered just after a rising edge with the DUT in FETCH; returns cycles until FETCH again
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, output int cyc);
    logic [3:0] seq[$];
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    seq.push_back(S_FETCH);
    seq.push_back(S_DECODE);
    case (o)
      OP_LW:  begin seq.push_back(S_MEMADR); seq.push_back(S_MEMREAD); seq.push_back(S_MEMWB); end
      OP_SW:  begin seq.push_back(S_MEMADR); seq.push_back(S_MEMWRITE); end
      OP_R:   begin seq.push_back(S_EXECUTER); seq.push_back(S_ALUWB); end
      OP_I:   begin seq.push_back(S_EXECUTEI); seq.push_back(S_ALUWB); end
      OP_JAL: begin seq.push_back(S_JAL); seq.push_back(S_ALUWB); end
      OP_BEQ: seq.push_back(S_BEQ);
      default: ;
    endcase
    foreach (seq[i]) sb.push_back(expv(seq[i], o, f3, f7, z));
    cyc = 99;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (state === S_FETCH) begin
        cyc = c;
        break;
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover op=%b actual=%0d expected=0 unconsumed vectors", o, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    int cyc;
    reset = 1; op = OP_LW; funct3 = 0; funct7b5 = 0; zero = 0;
    @(posedge clk); #1;
    sb.push_back(expv(S_FETCH, OP_LW, 3'b000, 1'b0, 1'b0));
    @(posedge clk); #1;
    checks++;
    if ({state, IRWrite, PCWrite, ALUSrcB} !== {S_FETCH, 1'b1, 1'b1, 2'b10}) begin
      errors++;
      $display("FAIL reset_fetch actual=%b expected=%b", {state, IRWrite, PCWrite, ALUSrcB},
               {S_FETCH, 1'b1, 1'b1, 2'b10});
    end
    reset = 0;
    run_instr(OP_LW, 3'b010, 1'b0, 1'b0, cyc);
    checks++;
    if (cyc != 5) begin errors++; $display("FAIL lw_cpi actual=%0d expected=5", cyc); end
  endtask

  task automatic test_rtype();
    logic [3:0] tbl[6] = '{4'b0001, 4'b0000, 4'b1110, 4'b1100, 4'b0100, 4'b0010};
    int cyc;
    foreach (tbl[i]) begin
      run_instr(OP_R, tbl[i][3:1], tbl[i][0], 1'b0, cyc);
      checks++;
      if (cyc != 4) begin errors++; $display("FAIL rtype_cpi f3=%b actual=%0d expected=4", tbl[i][3:1], cyc); end
    end
  endtask

  task automatic test_itype();
    int cyc;
    run_instr(OP_I, 3'b000, 1'b1, 1'b1, cyc);
    checks++;
    if (cyc != 4) begin errors++; $display("FAIL addi_cpi actual=%0d expected=4", cyc); end
    run_instr(OP_I, 3'b010, 1'b0, 1'b0, cyc);
    checks++;
    if (cyc != 4) begin errors++; $display("FAIL slti_cpi actual=%0d expected=4", cyc); end
  endtask

  task automatic test_beq();
    int cyc;
    run_instr(OP_BEQ, 3'b000, 1'b0, 1'b1, cyc);
    checks++;
    if (cyc != 3) begin errors++; $display("FAIL beq_taken_cpi actual=%0d expected=3", cyc); end
    run_instr(OP_BEQ, 3'b000, 1'b0, 1'b0, cyc);
    checks++;
    if (cyc != 3) begin errors++; $display("FAIL beq_nt_cpi actual=%0d expected=3", cyc); end
  endtask

  task automatic test_sw();
    int cyc;
    run_instr(OP_SW, 3'b010, 1'b0, 1'b0, cyc);
    checks++;
    if (cyc != 4) begin errors++; $display("FAIL sw_cpi actual=%0d expected=4", cyc); end
  endtask

  task automatic test_jal();
    int cyc;
    run_instr(OP_JAL, 3'b000, 1'b0, 1'b0, cyc);
    checks++;
    if (cyc != 4) begin errors++; $display("FAIL jal_cpi actual=%0d expected=4", cyc); end
  endtask

  task automatic test_illegal();
    int cyc;
    run_instr(OP_BAD, 3'b000, 1'b1, 1'b1, cyc);
    checks++;
    if (cyc != 2) begin errors++; $display("FAIL illegal_cpi actual=%0d expected=2", cyc); end
  endtask

  task automatic test_reset_midinstr();
    op = OP_SW; funct3 = 3'b010; funct7b5 = 0; zero = 0;
    sb.push_back(expv(S_FETCH, OP_SW, 3'b010, 1'b0, 1'b0));
    sb.push_back(expv(S_DECODE, OP_SW, 3'b010, 1'b0, 1'b0));
    sb.push_back(expv(S_MEMADR, OP_SW, 3'b010, 1'b0, 1'b0));
    sb.push_back(expv(S_MEMWRITE, OP_SW, 3'b010, 1'b0, 1'b0));
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    checks++;
    if ({state, MemWrite} !== {S_FETCH, 1'b0}) begin
      errors++;
      $display("FAIL reset_memwrite actual=%b expected=%b", {state, MemWrite}, {S_FETCH, 1'b0});
    end
    reset = 0;
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops[7] = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL, OP_BAD};
    logic [6:0] o;
    int cyc;
    for (int n = 0; n < 25; n++) begin
      o = ops[$urandom_range(0, 6)];
      run_instr(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), cyc);
      checks++;
      if (cyc != exp_cpi(o)) begin
        errors++;
        $display("FAIL b2b_cpi op=%b actual=%0d expected=%0d", o, cyc, exp_cpi(o));
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_beq();
    test_sw();
    test_jal();
    test_illegal();
    test_reset_midinstr();
    test_back_to_back();
    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
